// File: rtl/ysyx_24100005_ifu.sv
// -----------------------------------------------------------------------------
// ysyx_24100005_ifu -- instruction fetch unit
//
// Fetches one instruction at a time from a valid/ready memory port and hands
// it to decode through a valid/ready instruction port. At most one memory
// request is outstanding. An execute-stage redirect replaces the fetch PC and
// cancels whatever fetch is in flight or held. If the cancelled request was
// already accepted by memory, its response is awaited in DRAIN and discarded.
//
// Ports:
//   clk             in   1   single clock, rising edge
//   rst             in   1   asynchronous active-low reset
//   mem_req_valid   out  1   fetch request valid (REQ state only)
//   mem_req_ready   in   1   memory accepts request
//   mem_req_addr    out  32  fetch address (current pc)
//   mem_rsp_valid   in   1   fetch data valid, one per accepted request
//   mem_rsp_data    in   32  fetched instruction word
//   inst_valid      out  1   instruction available to decode (HOLD only)
//   inst_ready      in   1   decode consumes instruction
//   inst            out  32  held instruction
//   inst_pc         out  32  PC of held instruction
//   redirect_valid  in   1   PC redirect from execute
//   redirect_pc     in   32  redirect target (low two bits ignored)
// -----------------------------------------------------------------------------
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  // Instruction fetch is word aligned; the low two bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        req_valid_q, req_valid_d;
  logic        inst_valid_q, inst_valid_d;

  // Next-state, pc and instruction-capture logic; redirect overrides all events.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
      case (state_q)
        S_REQ: begin
          // An accepted request still owes a response that must be swallowed.
          if (mem_req_ready) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT, S_DRAIN: begin
          // A response arriving with the redirect settles the outstanding one.
          if (mem_rsp_valid) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: begin
          // IDLE and HOLD: nothing outstanding, refetch at once.
          state_d = S_REQ;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_REQ;
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            inst_d    = mem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_DRAIN: begin
          if (mem_rsp_valid) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    req_valid_d  = (state_d == S_REQ);
    inst_valid_d = (state_d == S_HOLD);
  end

  // State, pc, held instruction and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0000_0000;
      inst_pc_q    <= 32'h0000_0000;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = pc_q;
  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;

endmodule
